i2c_flash_master: RTL and testbench

//  Bus-initiator side of the serial flash interface. Generates SCL/SDA (open-drain) to run one complete

---
 rtl/i2c_flash_master.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_flash_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_flash_master.sv
// Open-drain serial bus initiator: START, device byte, 16-bit address (LSB first),
// N write or read data bytes, STOP.
module i2c_flash_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [6:0]  DEV_ID  = 7'h50,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             wr,
  input  logic [15:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic             scl,
  output logic             sda_out_en,
  input  logic             sda_in
);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DEVID  = 3'd2;
  localparam logic [2:0] S_ADDR_L = 3'd3;
  localparam logic [2:0] S_ADDR_H = 3'd4;
  localparam logic [2:0] S_WDATA  = 3'd5;
  localparam logic [2:0] S_RDATA  = 3'd6;
  localparam logic [2:0] S_STOP   = 3'd7;

  logic [2:0]       state, state_d;
  logic [1:0]       phase, phase_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [3:0]       bit_idx, bit_d;
  logic [7:0]       shreg, shreg_d;
  logic [LEN_W-1:0] left, left_d;
  logic [15:0]      addr, addr_d;
  logic             rd_cmd, rd_cmd_d;
  logic             nack, nack_d;
  logic             taken, taken_d;
  logic             rx_pend, rx_pend_d;
  logic             go_stop, byte_st;
  logic             cmd_ready_d, busy_d, done_d, ack_err_d, scl_d, sda_d;
  logic             tx_ready_d, rx_valid_d;
  logic [7:0]       rx_data_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      left       <= '0;
      addr       <= '0;
      rd_cmd     <= 1'b0;
      nack       <= 1'b0;
      taken      <= 1'b0;
      rx_pend    <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      scl        <= 1'b1;
      sda_out_en <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_d;
      shreg      <= shreg_d;
      left       <= left_d;
      addr       <= addr_d;
      rd_cmd     <= rd_cmd_d;
      nack       <= nack_d;
      taken      <= taken_d;
      rx_pend    <= rx_pend_d;
      cmd_ready  <= cmd_ready_d;
      busy       <= busy_d;
      done       <= done_d;
      ack_err    <= ack_err_d;
      tx_ready   <= tx_ready_d;
      rx_valid   <= rx_valid_d;
      rx_data    <= rx_data_d;
      scl        <= scl_d;
      sda_out_en <= sda_d;
    end
  end

  // Next state; outputs are decoded from the next-state values so they register in step
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    cnt_d      = cnt;
    bit_d      = bit_idx;
    shreg_d    = shreg;
    left_d     = left;
    addr_d     = addr;
    rd_cmd_d   = rd_cmd;
    nack_d     = nack;
    taken_d    = taken;
    rx_pend_d  = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data;
    ack_err_d  = ack_err;
    sda_d      = sda_out_en;
    go_stop    = 1'b0;
    byte_st    = (state >= S_DEVID) && (state <= S_RDATA);

    if (rx_pend) begin
      rx_data_d  = shreg;
      rx_valid_d = 1'b1;
    end
    if (tx_ready && tx_valid) begin
      taken_d = 1'b1;
      shreg_d = tx_data;
    end

    if (state == S_IDLE) begin
      if (cmd_valid && cmd_ready) begin
        state_d   = S_START;
        phase_d   = '0;
        cnt_d     = '0;
        bit_d     = '0;
        addr_d    = cmd_addr;
        rd_cmd_d  = wr;
        left_d    = cmd_len;
        nack_d    = 1'b0;
        taken_d   = 1'b0;
        ack_err_d = 1'b0;
      end
    end else if (cnt != CNT_LAST) begin
      cnt_d = cnt + 1'b1;
    end else if (!(state == S_WDATA && bit_idx == 4'd0 && phase == 2'd0 && !taken_d)) begin
      // Phase boundary; a data byte not yet supplied stretches Ph0 with SCL low
      cnt_d   = '0;
      phase_d = phase + 2'd1;
      case (phase)
        2'd0: begin
          if (byte_st) begin
            if (bit_idx != 4'd8)
              sda_d = (state == S_RDATA) ? 1'b0 : ~shreg_d[3'(4'd7 - bit_idx)];
            else
              sda_d = (state == S_RDATA) ? (left != LEN_W'(1)) : 1'b0;
          end
        end
        2'd1: begin
          if (state == S_START) sda_d = 1'b1;
          else if (state == S_STOP) sda_d = 1'b0;
        end
        2'd2: begin
          if (state == S_RDATA && bit_idx != 4'd8) begin
            shreg_d = {shreg[6:0], sda_in};
            rx_pend_d = (bit_idx == 4'd7);
          end else if (byte_st && bit_idx == 4'd8 && state != S_RDATA && sda_in) begin
            nack_d = 1'b1;
          end
        end
        default: begin
          if (state == S_START) begin
            state_d = S_DEVID;
            shreg_d = {DEV_ID, rd_cmd};
          end else if (state == S_STOP) begin
            state_d = S_IDLE;
          end else if (bit_idx != 4'd8) begin
            bit_d = bit_idx + 4'd1;
          end else begin
            bit_d   = '0;
            taken_d = 1'b0;
            case (state)
              S_DEVID: begin
                state_d = S_ADDR_L;
                shreg_d = addr[7:0];
              end
              S_ADDR_L: begin
                state_d = S_ADDR_H;
                shreg_d = addr[15:8];
              end
              S_ADDR_H: begin
                if (left == '0) go_stop = 1'b1;
                else state_d = rd_cmd ? S_RDATA : S_WDATA;
              end
              default: begin
                left_d  = left - 1'b1;
                go_stop = (left == LEN_W'(1));
              end
            endcase
            if (nack) go_stop = 1'b1;
            if (go_stop) begin
              state_d = S_STOP;
              sda_d   = 1'b1;
            end
          end
        end
      endcase
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_IDLE, S_START: scl_d = 1'b1;
      S_STOP:          scl_d = (phase_d != 2'd0);
      default:         scl_d = phase_d[1];
    endcase
    done_d     = (state_d == S_STOP) && (phase_d == 2'd3) && (cnt_d == CNT_LAST);
    tx_ready_d = (state_d == S_WDATA) && (bit_d == 4'd0) && (phase_d == 2'd0) && !taken_d;
    if (done_d && nack_d) ack_err_d = 1'b1;
  end
endmodule

// File: tb/tb_i2c_flash_master.sv
// Bench for i2c_flash_master: bus-level slave model plus scoreboard queues for
// bus bytes, read data and transaction completion.
module tb_i2c_flash_master;
  typedef struct {
    logic ack_err;
    int   rises;
    int   busy;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, busy, done, ack_err, scl, sda_out_en, sda_in;
  logic        slave_pull = 1'b0;
  logic        sda_bus;

  int tests = 0;
  int failed = 0;

  logic [8:0]  exp_bus[$];
  logic [7:0]  exp_rx[$];
  done_t       exp_done[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rd_q[$];

  logic        tx_hold = 1'b0;
  logic        nack_dev = 1'b0;
  logic        ready_seen = 1'b0;
  int          done_cnt = 0;
  int          busy_cnt = 0;

  int          bitcnt = 0, byte_no = 0, rises = 0, last_rises = 0;
  logic [7:0]  cur = 8'h00, rd_cur = 8'h00;
  logic        in_txn = 1'b0, rw = 1'b0, rd_go = 1'b0, rd_active = 1'b0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1;

  assign sda_bus = !(sda_out_en || slave_pull);
  assign sda_in  = sda_bus;

  always #5 clk = ~clk;

  i2c_flash_master #(.CLK_DIV(4), .DEV_ID(7'h50), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .wr(wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .ack_err(ack_err), .scl(scl), .sda_out_en(sda_out_en), .sda_in(sda_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: decodes START/STOP/bytes, ACKs, returns read data
  always @(negedge clk) begin
    if (rst) begin
      in_txn = 1'b0; slave_pull = 1'b0; bitcnt = 0; byte_no = 0;
      prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (scl && prev_scl && prev_sda && !sda_bus) begin
        in_txn = 1'b1; bitcnt = 0; byte_no = 0; rises = 0; rw = 1'b0; rd_go = 1'b1;
      end else if (in_txn && scl && prev_scl && !prev_sda && sda_bus) begin
        in_txn = 1'b0; last_rises = rises - 1; slave_pull = 1'b0;
      end else if (in_txn && scl && !prev_scl) begin
        rises++;
        if (bitcnt < 8) cur = {cur[6:0], sda_bus};
        else begin
          if (exp_bus.size() == 0) check("bus_byte_unexpected", exp_bus.size(), 1);
          else check("bus_byte", {cur, sda_bus}, exp_bus.pop_front());
          if (byte_no == 0) rw = cur[0];
          if (byte_no >= 3 && rw) rd_go = !sda_bus;
        end
        bitcnt++;
      end else if (in_txn && !scl && prev_scl) begin
        if (bitcnt == 9) begin bitcnt = 0; byte_no++; end
        slave_pull = 1'b0;
        if (byte_no >= 3 && rw) begin
          if (bitcnt == 0 && rd_go) begin
            rd_active = (rd_q.size() > 0);
            if (rd_active) rd_cur = rd_q.pop_front();
          end
          if (bitcnt < 8 && rd_go && rd_active) slave_pull = !rd_cur[7 - bitcnt];
        end else if (bitcnt == 8) begin
          slave_pull = !(byte_no == 0 && nack_dev);
        end
      end
      prev_scl = scl;
      prev_sda = sda_bus;
    end
  end

  // Write-data source honouring the ready/valid handshake
  always @(negedge clk) begin
    if (tx_valid && ready_seen && tx_q.size() > 0) void'(tx_q.pop_front());
    ready_seen = tx_ready;
    tx_valid = 1'b0;
    if (tx_ready) begin
      if (tx_q.size() == 0) check("tx_ready_unexpected", tx_q.size(), 1);
      else if (!tx_hold) begin
        tx_valid = 1'b1;
        tx_data  = tx_q[0];
      end
    end
  end

  // Read-data and completion monitors
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_rx.size() == 0) check("rx_unexpected", exp_rx.size(), 1);
      else check("rx_data", rx_data, exp_rx.pop_front());
    end
  end

  always @(negedge clk) begin
    done_t e;
    if (rst) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) check("done_unexpected", exp_done.size(), 1);
        else begin
          e = exp_done.pop_front();
          check("ack_err_at_done", ack_err, e.ack_err);
          check("scl_rises", last_rises, e.rises);
          if (e.busy >= 0) check("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] n);
    int t = 0;
    while (!cmd_ready && t < 5000) begin @(negedge clk); t++; end
    check("cmd_ready_wait", cmd_ready, 1);
    wr = w; cmd_addr = a; cmd_len = n; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int t = 0;
    while (done_cnt == start && t < 20000) begin @(negedge clk); t++; end
    check("done_seen", done_cnt != start, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int bad;
    logic sda0;
    rst = 1'b1; cmd_valid = 1'b0; wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_scl", scl, 1);
    check("rst_sda_out_en", sda_out_en, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write two bytes
    tx_q.push_back(8'hA5); tx_q.push_back(8'h3C);
    exp_bus.push_back({8'hA0, 1'b0}); exp_bus.push_back({8'h34, 1'b0});
    exp_bus.push_back({8'h12, 1'b0}); exp_bus.push_back({8'hA5, 1'b0});
    exp_bus.push_back({8'h3C, 1'b0});
    exp_done.push_back('{1'b0, 45, 752});
    issue(1'b0, 16'h1234, 8'd2);
    wait_done();

    // Read three bytes
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
    exp_bus.push_back({8'hA1, 1'b0}); exp_bus.push_back({8'hFF, 1'b0});
    exp_bus.push_back({8'h00, 1'b0}); exp_bus.push_back({8'h11, 1'b0});
    exp_bus.push_back({8'h22, 1'b0}); exp_bus.push_back({8'h33, 1'b1});
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h22); exp_rx.push_back(8'h33);
    exp_done.push_back('{1'b0, 54, 896});
    issue(1'b1, 16'h00FF, 8'd3);
    wait_done();

    // Device byte NACKed
    nack_dev = 1'b1;
    exp_bus.push_back({8'hA0, 1'b1});
    exp_done.push_back('{1'b1, 9, 176});
    issue(1'b0, 16'h0042, 8'd2);
    wait_done();
    nack_dev = 1'b0;
    repeat (5) @(negedge clk);
    check("ack_err_held", ack_err, 1);

    // Clock stretch while write data is withheld
    tx_hold = 1'b1;
    tx_q.push_back(8'h5A);
    exp_bus.push_back({8'hA0, 1'b0}); exp_bus.push_back({8'h77, 1'b0});
    exp_bus.push_back({8'h00, 1'b0}); exp_bus.push_back({8'h5A, 1'b0});
    exp_done.push_back('{1'b0, 36, -1});
    issue(1'b0, 16'h0077, 8'd1);
    check("ack_err_cleared", ack_err, 0);
    t = 0;
    while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
    check("tx_ready_seen", tx_ready, 1);
    sda0 = sda_out_en;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (scl !== 1'b0 || sda_out_en !== sda0) bad++;
    end
    check("stretch_hold", bad, 0);
    check("stretch_tx_ready", tx_ready, 1);
    tx_hold = 1'b0;
    wait_done();

    // Address-only transaction
    exp_bus.push_back({8'hA0, 1'b0}); exp_bus.push_back({8'hEF, 1'b0});
    exp_bus.push_back({8'hBE, 1'b0});
    exp_done.push_back('{1'b0, 27, 464});
    issue(1'b0, 16'hBEEF, 8'd0);
    wait_done();

    // Reset during read data bit 4
    rd_q.push_back(8'hC3); rd_q.push_back(8'h96);
    exp_bus.push_back({8'hA1, 1'b0}); exp_bus.push_back({8'h10, 1'b0});
    exp_bus.push_back({8'h00, 1'b0});
    issue(1'b1, 16'h0010, 8'd2);
    t = 0;
    while (!(byte_no == 3 && bitcnt == 4 && scl == 1'b0) && t < 5000) begin @(negedge clk); t++; end
    check("reached_rd_bit4", (byte_no == 3 && bitcnt == 4), 1);
    rst = 1'b1;
    #1;
    check("midrst_scl", scl, 1);
    check("midrst_sda_out_en", sda_out_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    rd_q.delete();
    @(negedge clk);

    // Clean write after the abandoned transaction
    tx_q.push_back(8'h99);
    exp_bus.push_back({8'hA0, 1'b0}); exp_bus.push_back({8'h5A, 1'b0});
    exp_bus.push_back({8'hA5, 1'b0}); exp_bus.push_back({8'h99, 1'b0});
    exp_done.push_back('{1'b0, 36, 608});
    issue(1'b0, 16'hA55A, 8'd1);
    wait_done();

    repeat (5) @(negedge clk);
    check("bus_q_drained", exp_bus.size(), 0);
    check("rx_q_drained", exp_rx.size(), 0);
    check("done_q_drained", exp_done.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
